best_neighbor_sel: RTL and testbench
====================================

BEST_NEIGHBOR_SEL -- requirements
Module: best_neighbor_sel

Interface
REQ-001 SHALL have parameter QVALUE_BASE, default 16'h01C8: byte address of the qValue table, entry i at QVALUE_BASE+2i.
REQ-002 SHALL have parameter NEIGHBOR_BASE, default 16'h0048: byte address of the neighborID table, entry i at NEIGHBOR_BASE+2i.
REQ-003 SHALL have parameter NEXTSINK_ADDR, default 16'h0700: destination address for the selected neighborID.
REQ-004 SHALL have parameter BETTERQ_ADDR, default 16'h0710: destination address for the selected qValue.
REQ-005 SHALL have ports: clock input 1 (sole clock); nrst input 1 (reset, synchronous, active-low).
REQ-006 SHALL have ports: start input 1 (scan request pulse); neighbor_count input 5 (table entries to scan, 0..16).
REQ-007 SHALL have ports: mem_address output 16; mem_wr_en output 1; mem_data_in output 16 (write data); mem_data_out input 16 (combinational read data for mem_address, same cycle).
REQ-008 SHALL have ports: busy output 1; done output 1 (one-cycle pulse); valid output 1; best_id output 16; best_q output 16.

Function
REQ-009 SHALL use states IDLE, RD_Q, RD_ID, WR_ID, WR_Q, DONE.
REQ-010 In IDLE with start=1, SHALL sample neighbor_count, clear index i to 0, clear the internal found flag, and go to RD_Q; if the sampled count is 0, SHALL go to WR_ID instead.
REQ-011 Count values above 16 SHALL be clamped to 16.
REQ-012 start SHALL be ignored in every state except IDLE.
REQ-013 RD_Q SHALL drive mem_address = QVALUE_BASE+2i.
REQ-014 In RD_Q, SHALL set a take flag when mem_data_out > best_q (unsigned 16-bit compare) or found=0; when the take flag is set it SHALL latch mem_data_out into a candidate register; then go to RD_ID.
REQ-015 RD_ID SHALL drive mem_address = NEIGHBOR_BASE+2i.
REQ-016 In RD_ID with the take flag set, SHALL load best_id from mem_data_out, load best_q from the candidate, and set found=1.
REQ-017 In RD_ID, SHALL increment i; when i = count-1 it SHALL go to WR_ID, otherwise to RD_Q.
REQ-018 Ties SHALL keep the lowest index, because the compare is strict.
REQ-019 WR_ID SHALL drive mem_address = NEXTSINK_ADDR, mem_wr_en=1, mem_data_in = best_id (16'hFFFF if found=0).
REQ-020 WR_Q SHALL drive mem_address = BETTERQ_ADDR, mem_wr_en=1, mem_data_in = best_q (0 if found=0).
REQ-021 DONE SHALL assert done=1 for exactly one cycle, then go to IDLE.
REQ-022 mem_wr_en SHALL be 1 only in WR_ID and WR_Q; in all other states mem_address SHALL be 0 and mem_data_in 0.
REQ-023 busy SHALL be 1 in every state except IDLE.
REQ-024 Latency: with start sampled at edge k and count N≥1, WR_ID SHALL occupy cycle k+2N+1, WR_Q cycle k+2N+2 and DONE cycle k+2N+3; with N=0 these SHALL be k+1, k+2 and k+3.
REQ-025 At start acceptance, best_id, best_q and valid SHALL clear to 0.
REQ-026 valid SHALL be set to found on entering DONE.
REQ-027 best_id, best_q and valid SHALL hold until the next accepted start.
REQ-028 i SHALL be 5 bits wide; address arithmetic SHALL be 16-bit and wrap modulo 2^16.

Reset
REQ-029 With nrst=0 at a clock edge, the block SHALL enter IDLE and clear i, found, take, candidate, best_id, best_q, valid, done, busy, mem_wr_en, mem_address and mem_data_in to 0.
REQ-030 Reset asserted mid-scan SHALL abort without any further memory write; a write cycle already in progress during the reset edge SHALL not be repeated afterwards.
REQ-031 start asserted during reset SHALL be ignored.

Verification
REQ-032 Default table contents, qValue[i]=16-i, neighborID[i]=i, N=16, start at edge k -> done in cycle k+35; best_id=0, best_q=16, valid=1; mem[0x700..0x701]=00 00; mem[0x710..0x711]=00 10.
REQ-033 Tie: qValue[3]=qValue[7]=0x0050, all others 1, N=16 -> best_id=3, best_q=0x0050.
REQ-034 N=0 -> done in cycle k+3, valid=0, mem 0x700 word=0xFFFF, 0x710 word=0x0000, no reads issued.
REQ-035 Unsigned compare: qValue[0]=0x7FFF, qValue[1]=0x8000, N=2 -> best_id=1, best_q=0x8000.
REQ-036 start re-pulsed while busy -> ignored, single done pulse; nrst=0 in cycle k+5 -> IDLE next cycle, all outputs 0, mem 0x700/0x710 unchanged.

Source files
------------

// File: rtl/best_neighbor_sel.sv
// Scans qValue/neighborID tables for the highest qValue (lowest index wins ties) and writes the winner out.
// Latency 2N+3 cycles from start to done (3 when N=0); start is only accepted in IDLE, with no stall input.
module best_neighbor_sel #(
  parameter logic [15:0] QVALUE_BASE   = 16'h01C8,
  parameter logic [15:0] NEIGHBOR_BASE = 16'h0048,
  parameter logic [15:0] NEXTSINK_ADDR = 16'h0700,
  parameter logic [15:0] BETTERQ_ADDR  = 16'h0710
) (
  input  logic        clock,
  input  logic        nrst,
  input  logic        start,
  input  logic [4:0]  neighbor_count,
  output logic [15:0] mem_address,
  output logic        mem_wr_en,
  output logic [15:0] mem_data_in,
  input  logic [15:0] mem_data_out,
  output logic        busy,
  output logic        done,
  output logic        valid,
  output logic [15:0] best_id,
  output logic [15:0] best_q
);

  typedef enum logic [2:0] {IDLE, RD_Q, RD_ID, WR_ID, WR_Q, DONE} state_t;

  state_t      state_q, state_d;
  logic [4:0]  i_q, i_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        found_q, found_d;
  logic        take_q, take_d;
  logic [15:0] cand_q, cand_d;
  logic [15:0] best_id_q, best_id_d;
  logic [15:0] best_q_q, best_q_d;
  logic        valid_q, valid_d;
  logic [15:0] idx_off;

  // Entries are 16-bit words, so the byte offset is 2*i.
  assign idx_off = {10'd0, i_q, 1'b0};

  always_ff @(posedge clock) begin
    if (!nrst) begin
      state_q   <= IDLE;
      i_q       <= 5'd0;
      cnt_q     <= 5'd0;
      found_q   <= 1'b0;
      take_q    <= 1'b0;
      cand_q    <= 16'd0;
      best_id_q <= 16'd0;
      best_q_q  <= 16'd0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      i_q       <= i_d;
      cnt_q     <= cnt_d;
      found_q   <= found_d;
      take_q    <= take_d;
      cand_q    <= cand_d;
      best_id_q <= best_id_d;
      best_q_q  <= best_q_d;
      valid_q   <= valid_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    i_d         = i_q;
    cnt_d       = cnt_q;
    found_d     = found_q;
    take_d      = take_q;
    cand_d      = cand_q;
    best_id_d   = best_id_q;
    best_q_d    = best_q_q;
    valid_d     = valid_q;
    mem_address = 16'd0;
    mem_wr_en   = 1'b0;
    mem_data_in = 16'd0;
    case (state_q)
      IDLE: begin
        if (start) begin
          cnt_d     = (neighbor_count > 5'd16) ? 5'd16 : neighbor_count;
          i_d       = 5'd0;
          found_d   = 1'b0;
          best_id_d = 16'd0;
          best_q_d  = 16'd0;
          valid_d   = 1'b0;
          state_d   = (neighbor_count == 5'd0) ? WR_ID : RD_Q;
        end
      end
      RD_Q: begin
        mem_address = QVALUE_BASE + idx_off;
        // Strict compare keeps the earliest index on ties; the first entry is always taken.
        take_d = (mem_data_out > best_q_q) || !found_q;
        if (take_d) cand_d = mem_data_out;
        state_d = RD_ID;
      end
      RD_ID: begin
        mem_address = NEIGHBOR_BASE + idx_off;
        if (take_q) begin
          best_id_d = mem_data_out;
          best_q_d  = cand_q;
          found_d   = 1'b1;
        end
        i_d     = i_q + 5'd1;
        state_d = (i_q == cnt_q - 5'd1) ? WR_ID : RD_Q;
      end
      WR_ID: begin
        mem_address = NEXTSINK_ADDR;
        mem_wr_en   = 1'b1;
        mem_data_in = found_q ? best_id_q : 16'hFFFF;
        state_d     = WR_Q;
      end
      WR_Q: begin
        mem_address = BETTERQ_ADDR;
        mem_wr_en   = 1'b1;
        mem_data_in = found_q ? best_q_q : 16'd0;
        valid_d     = found_q;
        state_d     = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy    = (state_q != IDLE);
  assign done    = (state_q == DONE);
  assign valid   = valid_q;
  assign best_id = best_id_q;
  assign best_q  = best_q_q;

endmodule

// File: tb/tb_best_neighbor_sel.sv
// Directed scenarios for best_neighbor_sel; expected results are queued at issue time and checked by a done-triggered monitor.
module tb_best_neighbor_sel;

  localparam logic [15:0] QB = 16'h01C8;
  localparam logic [15:0] NB = 16'h0048;
  localparam logic [15:0] SA = 16'h0700;
  localparam logic [15:0] BA = 16'h0710;

  logic        clock = 1'b0;
  logic        nrst;
  logic        start;
  logic [4:0]  neighbor_count;
  logic [15:0] mem_address;
  logic        mem_wr_en;
  logic [15:0] mem_data_in;
  logic [15:0] mem_data_out;
  logic        busy, done, valid;
  logic [15:0] best_id, best_q;

  best_neighbor_sel dut (
    .clock(clock), .nrst(nrst), .start(start), .neighbor_count(neighbor_count),
    .mem_address(mem_address), .mem_wr_en(mem_wr_en), .mem_data_in(mem_data_in),
    .mem_data_out(mem_data_out), .busy(busy), .done(done), .valid(valid),
    .best_id(best_id), .best_q(best_q)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  logic [15:0] mem [0:65535];
  logic        tb_we = 1'b0;
  logic [15:0] tb_wa = 16'd0;
  logic [15:0] tb_wd = 16'd0;
  assign mem_data_out = mem[mem_address];
  always @(posedge clock) begin
    if (mem_wr_en) mem[mem_address] <= mem_data_in;
    else if (tb_we) mem[tb_wa] <= tb_wd;
  end

  typedef struct {
    int          start_cyc;
    int          lat;
    int          reads;
    logic [15:0] id;
    logic [15:0] q;
    logic        vld;
    logic [15:0] w_id;
    logic [15:0] w_q;
  } exp_t;
  exp_t sbq[$];

  int n_pass = 0;
  int n_total = 0;
  int reads = 0;
  logic [15:0] qtab [0:16];
  logic [15:0] idtab [0:16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  // Monitor: count read cycles per scan, compare everything when done pulses.
  always @(negedge clock) begin
    exp_t e;
    if (!busy) reads = 0;
    else if (!mem_wr_en && !done) reads++;
    if (done) begin
      if (sbq.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = sbq.pop_front();
        chk("latency", cyc - e.start_cyc, e.lat);
        chk("read_cycles", reads, e.reads);
        chk("best_id", best_id, e.id);
        chk("best_q", best_q, e.q);
        chk("valid", valid, e.vld);
        chk("mem_nextsink", mem[SA], e.w_id);
        chk("mem_betterq", mem[BA], e.w_q);
      end
    end
  end

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    tb_we = 1'b1; tb_wa = a; tb_wd = d;
    @(negedge clock);
    tb_we = 1'b0;
  endtask

  task automatic load(input int n);
    for (int i = 0; i < n; i++) begin
      wr(QB + 16'(2 * i), qtab[i]);
      wr(NB + 16'(2 * i), idtab[i]);
    end
    wr(SA, 16'hDEAD);
    wr(BA, 16'hBEEF);
  endtask

  task automatic run(input int n, input int lat, input int rds, input logic [15:0] id,
                     input logic [15:0] q, input logic vld, input logic [15:0] wid,
                     input logic [15:0] wq, input bit repulse);
    exp_t e;
    int t;
    e.start_cyc = cyc; e.lat = lat; e.reads = rds; e.id = id; e.q = q;
    e.vld = vld; e.w_id = wid; e.w_q = wq;
    sbq.push_back(e);
    start = 1'b1;
    neighbor_count = 5'(n);
    @(negedge clock);
    start = 1'b0;
    chk("clr_best_id", best_id, 16'd0);
    chk("clr_valid", valid, 1'b0);
    chk("busy_after_start", busy, 1'b1);
    if (repulse) begin
      @(negedge clock);
      start = 1'b1;
      neighbor_count = 5'd1;
      @(negedge clock);
      start = 1'b0;
    end
    t = 0;
    while (sbq.size() != 0 && t < 200) begin
      @(negedge clock);
      t++;
    end
    if (sbq.size() != 0) begin
      chk("done_timeout", 32'd0, 32'd1);
      sbq.delete();
    end
    repeat (4) @(negedge clock);
    chk("idle_after_done", busy, 1'b0);
  endtask

  initial begin
    nrst = 1'b0;
    start = 1'b1;
    neighbor_count = 5'd5;
    repeat (3) @(negedge clock);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_outs", {valid, best_id, best_q}, 33'd0);
    chk("rst_mem_if", {mem_wr_en, mem_address, mem_data_in}, 33'd0);
    nrst = 1'b1;
    start = 1'b0;
    @(negedge clock);
    chk("idle_after_rst", busy, 1'b0);

    // Descending table: entry 0 wins.
    for (int i = 0; i < 16; i++) begin qtab[i] = 16'(16 - i); idtab[i] = 16'(i); end
    load(16);
    run(16, 35, 32, 16'd0, 16'd16, 1'b1, 16'h0000, 16'h0010, 1'b0);

    // Tie between entries 3 and 7.
    for (int i = 0; i < 16; i++) qtab[i] = 16'd1;
    qtab[3] = 16'h0050; qtab[7] = 16'h0050;
    load(16);
    run(16, 35, 32, 16'd3, 16'h0050, 1'b1, 16'h0003, 16'h0050, 1'b0);

    // Empty scan.
    load(0);
    run(0, 3, 0, 16'd0, 16'd0, 1'b0, 16'hFFFF, 16'h0000, 1'b0);

    // Unsigned compare.
    qtab[0] = 16'h7FFF; qtab[1] = 16'h8000; idtab[0] = 16'h0100; idtab[1] = 16'h0101;
    load(2);
    run(2, 7, 4, 16'h0101, 16'h8000, 1'b1, 16'h0101, 16'h8000, 1'b0);
    chk("hold_best_id", best_id, 16'h0101);
    chk("hold_valid", valid, 1'b1);

    // Count 31 clamps to 16; entry 16 holds a bigger value that must not be read.
    for (int i = 0; i < 16; i++) begin qtab[i] = 16'(3 * i); idtab[i] = 16'(16'h00A0 + i); end
    qtab[16] = 16'hFFFF; idtab[16] = 16'hBEEF;
    load(17);
    run(31, 35, 32, 16'h00AF, 16'd45, 1'b1, 16'h00AF, 16'd45, 1'b0);

    // start re-pulsed mid-scan is ignored.
    qtab[0] = 16'd5; qtab[1] = 16'd9; qtab[2] = 16'd2;
    idtab[0] = 16'h0011; idtab[1] = 16'h0012; idtab[2] = 16'h0013;
    load(3);
    run(3, 9, 6, 16'h0012, 16'd9, 1'b1, 16'h0012, 16'd9, 1'b1);

    // Reset mid-scan at cycle k+5, with start held high through reset.
    for (int i = 0; i < 16; i++) begin qtab[i] = 16'(i + 1); idtab[i] = 16'(16'h0200 + i); end
    load(16);
    wr(SA, 16'h1234);
    wr(BA, 16'h5678);
    start = 1'b1;
    neighbor_count = 5'd16;
    @(negedge clock);
    start = 1'b0;
    repeat (4) @(negedge clock);
    nrst = 1'b0;
    start = 1'b1;
    @(negedge clock);
    chk("abort_busy", busy, 1'b0);
    chk("abort_outs", {done, valid, best_id, best_q}, 34'd0);
    chk("abort_mem_if", {mem_wr_en, mem_address, mem_data_in}, 33'd0);
    nrst = 1'b1;
    start = 1'b0;
    repeat (40) @(negedge clock);
    chk("abort_stays_idle", busy, 1'b0);
    chk("abort_mem_nextsink", mem[SA], 16'h1234);
    chk("abort_mem_betterq", mem[BA], 16'h5678);

    // Single entry with qValue 0 is still taken.
    qtab[0] = 16'd0; idtab[0] = 16'h0042;
    load(1);
    run(1, 5, 2, 16'h0042, 16'd0, 1'b1, 16'h0042, 16'd0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
